// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes and FSM states.
package mem_pkg;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// MEM-stage <-> data-memory handshake bundle.
interface data_memory_responder_if;
    logic        READ;
    logic        WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        ACCESS_ERROR;

    modport master (
        output READ, WRITE, FUNCT3, ADDRESS, WRITEDATA,
        input  READDATA, BUSYWAIT, ACCESS_ERROR
    );

    modport slave (
        input  READ, WRITE, FUNCT3, ADDRESS, WRITEDATA,
        output READDATA, BUSYWAIT, ACCESS_ERROR
    );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] new_word,
    output logic        store_err,
    output logic [31:0] load_data,
    output logic        load_err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = word[{lane[1], 4'b0000} +: 16];

    // Merge store data into the addressed lanes; illegal/misaligned leaves the word untouched
    always_comb begin
        new_word  = word;
        store_err = 1'b0;
        case (funct3)
            F3_B: new_word[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[0]) store_err = 1'b1;
                else         new_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            F3_W: begin
                if (lane != 2'b00) store_err = 1'b1;
                else               new_word = wdata;
            end
            default: store_err = 1'b1;
        endcase
        if (store_err) new_word = word;
    end

    // Extract and extend load data; errors return zero
    always_comb begin
        load_data = 32'h0;
        load_err  = 1'b0;
        case (funct3)
            F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU: load_data = {24'h0, byte_sel};
            F3_H:  begin
                if (lane[0]) load_err = 1'b1;
                else         load_data = {{16{half_sel[15]}}, half_sel};
            end
            F3_HU: begin
                if (lane[0]) load_err = 1'b1;
                else         load_data = {16'h0, half_sel};
            end
            F3_W:  begin
                if (lane != 2'b00) load_err = 1'b1;
                else               load_data = word;
            end
            default: load_err = 1'b1;
        endcase
        if (load_err) load_data = 32'h0;
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: fixed-latency BUSYWAIT handshake over a word-organised array.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS_LOG2 = 8,
    parameter int unsigned LATENCY        = 4
) (
    input logic                    CLK,
    input logic                    RESET,
    data_memory_responder_if.slave bus
);

    localparam int unsigned DEPTH = 1 << MEM_WORDS_LOG2;
    localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                f3_q;
    logic [MEM_WORDS_LOG2-1:0] idx_q;
    logic [1:0]                lane_q;
    logic [31:0]               wdata_q;
    logic                      write_q;

    logic [31:0] mem [DEPTH];

    logic                      req;
    logic                      live;
    logic [2:0]                cur_f3;
    logic [MEM_WORDS_LOG2-1:0] cur_idx;
    logic [1:0]                cur_lane;
    logic [31:0]               cur_wdata;
    logic                      cur_write;
    logic [31:0]               old_word;
    logic [31:0]               new_word;
    logic                      store_err;
    logic [31:0]               load_data;
    logic                      load_err;
    logic                      do_access;
    logic                      unused_addr_hi;

    assign req = bus.READ | bus.WRITE;
    assign bus.BUSYWAIT = req && (state_q != DONE);

    // With LATENCY=1 the access happens straight out of IDLE, so it must use the live request
    assign live      = (state_q == IDLE);
    assign cur_f3    = live ? bus.FUNCT3 : f3_q;
    assign cur_idx   = live ? bus.ADDRESS[MEM_WORDS_LOG2+1:2] : idx_q;
    assign cur_lane  = live ? bus.ADDRESS[1:0] : lane_q;
    assign cur_wdata = live ? bus.WRITEDATA : wdata_q;
    assign cur_write = live ? bus.WRITE : write_q;
    assign old_word  = mem[cur_idx];

    // Upper address bits alias the array
    assign unused_addr_hi = ^bus.ADDRESS[31:MEM_WORDS_LOG2+2];

    assign do_access = ((state_q == ACCESS) && (cnt_q == CNT_W'(1)))
                    || (live && req && (LATENCY == 1));

    load_store_align u_align (
        .funct3    (cur_f3),
        .lane      (cur_lane),
        .wdata     (cur_wdata),
        .word      (old_word),
        .new_word  (new_word),
        .store_err (store_err),
        .load_data (load_data),
        .load_err  (load_err)
    );

    // Array write on the completing edge; reset suppresses it
    always_ff @(posedge CLK) begin
        if (!RESET && do_access && cur_write && !store_err) begin
            mem[cur_idx] <= new_word;
        end
    end

    // Handshake FSM with latched request, latency counter and registered results
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            f3_q             <= '0;
            idx_q            <= '0;
            lane_q           <= '0;
            wdata_q          <= '0;
            write_q          <= 1'b0;
            bus.READDATA     <= 32'h0;
            bus.ACCESS_ERROR <= 1'b0;
        end else begin
            if (do_access) begin
                if (cur_write) begin
                    bus.READDATA     <= 32'h0;
                    bus.ACCESS_ERROR <= store_err;
                end else begin
                    bus.READDATA     <= load_data;
                    bus.ACCESS_ERROR <= load_err;
                end
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        f3_q    <= bus.FUNCT3;
                        idx_q   <= bus.ADDRESS[MEM_WORDS_LOG2+1:2];
                        lane_q  <= bus.ADDRESS[1:0];
                        wdata_q <= bus.WRITEDATA;
                        write_q <= bus.WRITE;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 1) ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= DONE;
                end
                DONE: begin
                    bus.ACCESS_ERROR <= 1'b0;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder at LATENCY=4 and LATENCY=1.
module tb_data_memory_responder;
    import mem_pkg::*;

    logic clk;
    logic rst4;
    logic rst1;
    int   n_checks;
    int   n_fail;

    data_memory_responder_if bus4 ();
    data_memory_responder_if bus1 ();

    data_memory_responder #(.MEM_WORDS_LOG2(8), .LATENCY(4)) dut4 (
        .CLK   (clk),
        .RESET (rst4),
        .bus   (bus4.slave)
    );

    data_memory_responder #(.MEM_WORDS_LOG2(8), .LATENCY(1)) dut1 (
        .CLK   (clk),
        .RESET (rst1),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int sel, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 1) begin
            bus1.READ = rd; bus1.WRITE = wr; bus1.FUNCT3 = f3;
            bus1.ADDRESS = addr; bus1.WRITEDATA = wdata;
        end else begin
            bus4.READ = rd; bus4.WRITE = wr; bus4.FUNCT3 = f3;
            bus4.ADDRESS = addr; bus4.WRITEDATA = wdata;
        end
    endtask

    task automatic release_req(input int sel);
        if (sel == 1) begin
            bus1.READ = 1'b0; bus1.WRITE = 1'b0;
        end else begin
            bus4.READ = 1'b0; bus4.WRITE = 1'b0;
        end
    endtask

    // Called at posedge+1 with the request applied; returns at posedge+1 after DONE
    task automatic wait_done(input int sel, output int busy, output logic [31:0] rdata,
                             output logic err);
        logic bw;
        bit   seen;
        busy  = 0;
        seen  = 0;
        rdata = 'x;
        err   = 1'bx;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bw = (sel == 1) ? bus1.BUSYWAIT : bus4.BUSYWAIT;
            if (bw) begin
                busy++;
                @(posedge clk); #1;
            end else begin
                rdata = (sel == 1) ? bus1.READDATA : bus4.READDATA;
                err   = (sel == 1) ? bus1.ACCESS_ERROR : bus4.ACCESS_ERROR;
                seen  = 1;
                break;
            end
        end
        if (seen) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic xact(input int sel, input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_busy, input bit chk_rdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
        int          busy;
        logic [31:0] rdata;
        logic        err;
        drive_req(sel, rd, wr, f3, addr, wdata);
        wait_done(sel, busy, rdata, err);
        release_req(sel);
        check({tag, "/busy"}, busy, exp_busy);
        check({tag, "/err"}, {31'h0, err}, {31'h0, exp_err});
        if (chk_rdata) check({tag, "/rdata"}, rdata, exp_rdata);
    endtask

    initial begin
        int          busy;
        logic [31:0] rdata;
        logic        err;
        n_checks = 0;
        n_fail   = 0;
        rst4 = 1'b1;
        rst1 = 1'b1;
        drive_req(4, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst/rdata", bus4.READDATA, 32'h0);
        check("rst/err", {31'h0, bus4.ACCESS_ERROR}, 32'h0);
        check("rst/busy", {31'h0, bus4.BUSYWAIT}, 32'h0);
        rst4 = 1'b0;
        rst1 = 1'b0;
        @(posedge clk); #1;

        // SW then LW
        xact(4, "sw10", 1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 4, 1'b0, 32'h0, 1'b0);
        xact(4, "lw10", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 4, 1'b1, 32'hDEADBEEF, 1'b0);

        // Byte lanes
        xact(4, "sw20", 1'b0, 1'b1, F3_W, 32'h20, 32'h11223344, 4, 1'b0, 32'h0, 1'b0);
        xact(4, "sb21", 1'b0, 1'b1, F3_B, 32'h21, 32'h000000F0, 4, 1'b0, 32'h0, 1'b0);
        xact(4, "lb21", 1'b1, 1'b0, F3_B, 32'h21, 32'h0, 4, 1'b1, 32'hFFFFFFF0, 1'b0);
        xact(4, "lbu21", 1'b1, 1'b0, F3_BU, 32'h21, 32'h0, 4, 1'b1, 32'h000000F0, 1'b0);
        xact(4, "lw20a", 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 4, 1'b1, 32'h1122F044, 1'b0);

        // Halfword
        xact(4, "sh22", 1'b0, 1'b1, F3_H, 32'h22, 32'h00008001, 4, 1'b0, 32'h0, 1'b0);
        xact(4, "lh22", 1'b1, 1'b0, F3_H, 32'h22, 32'h0, 4, 1'b1, 32'hFFFF8001, 1'b0);
        xact(4, "lhu22", 1'b1, 1'b0, F3_HU, 32'h22, 32'h0, 4, 1'b1, 32'h00008001, 1'b0);
        xact(4, "lhu20", 1'b1, 1'b0, F3_HU, 32'h20, 32'h0, 4, 1'b1, 32'h0000F044, 1'b0);

        // Misaligned and illegal
        xact(4, "lw23", 1'b1, 1'b0, F3_W, 32'h23, 32'h0, 4, 1'b1, 32'h0, 1'b1);
        check("err_cleared", {31'h0, bus4.ACCESS_ERROR}, 32'h0);
        xact(4, "s_f3_100", 1'b0, 1'b1, F3_BU, 32'h20, 32'hFFFFFFFF, 4, 1'b1, 32'h0, 1'b1);
        xact(4, "lw20b", 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 4, 1'b1, 32'h8001F044, 1'b0);

        // Request dropped during ACCESS still completes
        drive_req(4, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        @(posedge clk); #1;
        release_req(4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drop/hold", bus4.READDATA, 32'h8001F044);
        @(posedge clk); #1;
        check("drop/rdata", bus4.READDATA, 32'hDEADBEEF);
        check("drop/err", {31'h0, bus4.ACCESS_ERROR}, 32'h0);
        @(posedge clk); #1;

        // READ and WRITE together act as a store
        xact(4, "rw30", 1'b1, 1'b1, F3_W, 32'h30, 32'h12345678, 4, 1'b1, 32'h0, 1'b0);
        xact(4, "lw30", 1'b1, 1'b0, F3_W, 32'h30, 32'h0, 4, 1'b1, 32'h12345678, 1'b0);
        // Upper address bits alias
        xact(4, "lw_alias", 1'b1, 1'b0, F3_W, 32'h00000430, 32'h0, 4, 1'b1, 32'h12345678, 1'b0);

        // LATENCY=1
        xact(1, "l1_sw", 1'b0, 1'b1, F3_W, 32'h4, 32'hA5A5A5A5, 1, 1'b0, 32'h0, 1'b0);
        xact(1, "l1_lw", 1'b1, 1'b0, F3_W, 32'h4, 32'h0, 1, 1'b1, 32'hA5A5A5A5, 1'b0);
        xact(1, "l1_lh5", 1'b1, 1'b0, F3_H, 32'h5, 32'h0, 1, 1'b1, 32'h0, 1'b1);
        xact(1, "l1_lbu7", 1'b1, 1'b0, F3_BU, 32'h7, 32'h0, 1, 1'b1, 32'h000000A5, 1'b0);

        // Reset mid-access with the request held
        drive_req(4, 1'b0, 1'b1, F3_W, 32'h40, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        check("midrst/rdata", bus4.READDATA, 32'h0);
        check("midrst/err", {31'h0, bus4.ACCESS_ERROR}, 32'h0);
        check("midrst/busy", {31'h0, bus4.BUSYWAIT}, 32'h1);
        wait_done(4, busy, rdata, err);
        release_req(4);
        check("midrst/busy_cnt", busy, 4);
        check("midrst/done_err", {31'h0, err}, 32'h0);
        xact(4, "lw40", 1'b1, 1'b0, F3_W, 32'h40, 32'h0, 4, 1'b1, 32'hCAFEF00D, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the MEM-stage data-memory handshake in the RV32IM pipeline.
- Accepts load/store requests from the MEM stage and asserts BUSYWAIT for a fixed access latency. This stalls the MEM/WB and upstream pipeline registers.
- Returns byte/half/word load data, sign- or zero-extended, on READDATA for capture into the writeback path.
- Holds a word-organised on-chip data array.

Parameters:
- MEM_WORDS_LOG2, 8, log2 of array depth in 32-bit words (default 256 words = 1 KiB).
- LATENCY, 4, cycles BUSYWAIT stays high per request. Legal range ≥1.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  load request; held by the MEM stage until BUSYWAIT is seen low.
- WRITE  in  1  store request; held the same way.
- FUNCT3  in  3  RV32 load/store funct3.
- ADDRESS  in  32  byte address.
- WRITEDATA  in  32  store data, right-aligned.
- READDATA  out  32  extended load result.
- BUSYWAIT  out  1  stall request to the pipeline.
- ACCESS_ERROR  out  1  high during DONE for an illegal or misaligned request.

Behaviour:
- Reset:
  - state=IDLE, counter=0, READDATA=0, ACCESS_ERROR=0.
  - BUSYWAIT follows its combinational rule, so it is high again if a request is present after reset.
  - Array contents are not cleared.
  - Reset mid-access aborts the access; no write is performed.
- States: IDLE, ACCESS, DONE.
- BUSYWAIT is combinational: `(READ|WRITE) && state!=DONE`. It rises in the same cycle a request first appears, so the pipeline never advances past an unserved request.
- IDLE:
  - If READ|WRITE: latch ADDRESS, FUNCT3, WRITEDATA and operation; counter=LATENCY-1.
  - Go to ACCESS, or go directly to DONE performing the access when LATENCY=1.
- ACCESS: counter decrements each cycle. On the edge where counter==1, perform the access (array write, or READDATA load) and go to DONE.
- DONE:
  - BUSYWAIT=0; READDATA and ACCESS_ERROR are stable. The pipeline captures at the next edge.
  - Then go to IDLE unconditionally.
  - A new request in the following cycle starts a fresh access. Each request therefore sees exactly LATENCY cycles of BUSYWAIT followed by one non-busy cycle.
- Request dropped (READ=WRITE=0) while in ACCESS: access completes anyway, goes through DONE, then IDLE.
- FUNCT3 decode:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Stores with 100/101, and any other code, are illegal.
- Word index = ADDRESS[MEM_WORDS_LOG2+1:2]. Upper address bits are ignored, so the array aliases modulo its size.
- Byte lane = ADDRESS[1:0].
- Misaligned access: halfword with ADDRESS[0]=1, or word with ADDRESS[1:0]≠0.
- Illegal or misaligned access:
  - No array write; READDATA=0; ACCESS_ERROR=1 in DONE.
  - Latency is unchanged.
- Stores modify only the addressed byte lanes; other lanes are preserved.
- Loads:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- READ and WRITE both high: treated as WRITE; READDATA=0.
- READDATA holds its last value outside DONE.
- ACCESS_ERROR is 0 outside DONE.

Decomposition:
- Shared package `mem_pkg`:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding for IDLE/ACCESS/DONE.
- Sub-module `load_store_align`, purely combinational, two functions:
  - Store side: (funct3, lane, wdata, old_word) → new_word plus an illegal/misaligned flag.
  - Load side: (funct3, lane, word) → extended data plus flag.
- The FSM, counter and array stay in `data_memory_responder`.

Test Plan:
- SW then LW, LATENCY=4:
  - Stimulus: WRITE=1, F3=010, ADDR=0x10, DATA=0xDEADBEEF; then READ same address.
  - Response: BUSYWAIT high exactly 4 cycles per request; READDATA=0xDEADBEEF in DONE; ACCESS_ERROR=0.
- Byte lanes:
  - Stimulus: SW 0x11223344 at 0x20; SB 0x000000F0 at 0x21; then LB, LBU and LW at 0x21.
  - Response: LB=0xFFFFFFF0, LBU=0x000000F0, LW=0x1122F044.
- Halfword:
  - Stimulus: SH 0x8001 at 0x22; then LH and LHU at 0x22.
  - Response: LH=0xFFFF8001, LHU=0x00008001; lower half unchanged (0xF044).
- Misaligned and illegal:
  - Stimulus: LW at 0x23; separately, a store with F3=100.
  - Response: BUSYWAIT 4 cycles, then ACCESS_ERROR=1 and READDATA=0; no array change on re-read.
- Back-to-back and LATENCY=1:
  - Stimulus: request re-asserted the cycle after DONE.
  - Response: BUSYWAIT rises immediately; with LATENCY=1, the pattern is 1 busy cycle then 1 DONE cycle.
- RESET mid-access:
  - Stimulus: SW 0xCAFEF00D at 0x40 with RESET pulsed at busy cycle 2, request held.
  - Response: access restarts and gets 4 full busy cycles; the final LW returns 0xCAFEF00D (aborted first attempt did not partially write).
